// File: rtl/res_station_bank_if.sv
// Dispatch, CDB and issue signal bundle for the reservation station bank.
// The bank takes the slave modport; the dispatch/CDB/FU side takes the master modport.
interface res_station_bank_if #(
  parameter int data_width  = 16,
  parameter int tag_width   = 3,
  parameter int num_entries = 4,
  parameter int op_width    = 4
);
  localparam int count_width = $clog2(num_entries + 1);

  logic                   disp_valid;
  logic [op_width-1:0]    disp_op;
  logic [data_width-1:0]  disp_Vj;
  logic [data_width-1:0]  disp_Vk;
  logic [tag_width-1:0]   disp_Qj;
  logic [tag_width-1:0]   disp_Qk;
  logic                   disp_Vj_valid;
  logic                   disp_Vk_valid;
  logic [tag_width-1:0]   disp_dest;
  logic                   full;
  logic [count_width-1:0] count;

  logic                   cdb_valid;
  logic [tag_width-1:0]   cdb_tag;
  logic [data_width-1:0]  cdb_data;

  logic                   issue_ready;
  logic                   issue_valid;
  logic [op_width-1:0]    issue_op;
  logic [data_width-1:0]  issue_Vj;
  logic [data_width-1:0]  issue_Vk;
  logic [tag_width-1:0]   issue_dest;

  modport master (
    output disp_valid, disp_op, disp_Vj, disp_Vk, disp_Qj, disp_Qk,
           disp_Vj_valid, disp_Vk_valid, disp_dest,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  full, count, issue_valid, issue_op, issue_Vj, issue_Vk, issue_dest
  );

  modport slave (
    input  disp_valid, disp_op, disp_Vj, disp_Vk, disp_Qj, disp_Qk,
           disp_Vj_valid, disp_Vk_valid, disp_dest,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    output full, count, issue_valid, issue_op, issue_Vj, issue_Vk, issue_dest
  );
endinterface

// File: rtl/res_station_bank.sv
// N-entry reservation station bank: lowest-free allocation, CDB operand wakeup
// with dispatch bypass, and oldest-ready-first issue to one functional unit.
module res_station_bank #(
  parameter int data_width  = 16,
  parameter int tag_width   = 3,
  parameter int num_entries = 4,
  parameter int op_width    = 4
) (
  input  logic               clk,
  input  logic               flush,
  res_station_bank_if.slave  bus
);
  localparam int count_width = $clog2(num_entries + 1);

  logic [num_entries-1:0] busy_reg;
  logic [num_entries-1:0] vj_valid_reg;
  logic [num_entries-1:0] vk_valid_reg;
  logic [op_width-1:0]    op_reg   [num_entries];
  logic [data_width-1:0]  vj_reg   [num_entries];
  logic [data_width-1:0]  vk_reg   [num_entries];
  logic [tag_width-1:0]   qj_reg   [num_entries];
  logic [tag_width-1:0]   qk_reg   [num_entries];
  logic [tag_width-1:0]   dest_reg [num_entries];
  // older_reg[i][j] set means entry i was dispatched before entry j
  logic [num_entries-1:0] older_reg [num_entries];

  logic [num_entries-1:0] ready;
  logic [num_entries-1:0] sel;
  logic [num_entries-1:0] alloc_oh;
  logic [count_width-1:0] count_comb;
  logic                   full;
  logic                   disp_accept;
  logic                   issue_fire;
  logic                   bypass_j;
  logic                   bypass_k;
  logic [data_width-1:0]  new_vj;
  logic [data_width-1:0]  new_vk;

  assign ready = busy_reg & vj_valid_reg & vk_valid_reg;

  // An entry is selected when it is ready and no older entry is ready.
  generate
    for (genvar gi = 0; gi < num_entries; gi++) begin : g_sel
      logic [num_entries-1:0] older_ready;
      for (genvar gj = 0; gj < num_entries; gj++) begin : g_col
        if (gj == gi) begin : g_self
          assign older_ready[gj] = 1'b0;
        end else begin : g_other
          assign older_ready[gj] = ready[gj] && older_reg[gj][gi];
        end
      end
      assign sel[gi] = ready[gi] && !(|older_ready);
    end
  endgenerate

  // Descending scan so the lowest free index wins.
  always_comb begin
    alloc_oh = '0;
    for (int i = num_entries - 1; i >= 0; i--) begin
      if (!busy_reg[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    count_comb = '0;
    for (int i = 0; i < num_entries; i++) begin
      count_comb = count_comb + count_width'(busy_reg[i]);
    end
  end

  assign full        = &busy_reg;
  assign disp_accept = bus.disp_valid && !full;
  assign issue_fire  = bus.issue_ready && (|sel);

  assign bypass_j = bus.cdb_valid && !bus.disp_Vj_valid && (bus.disp_Qj == bus.cdb_tag);
  assign bypass_k = bus.cdb_valid && !bus.disp_Vk_valid && (bus.disp_Qk == bus.cdb_tag);
  assign new_vj   = bypass_j ? bus.cdb_data : bus.disp_Vj;
  assign new_vk   = bypass_k ? bus.cdb_data : bus.disp_Vk;

  always_comb begin
    bus.issue_op   = '0;
    bus.issue_Vj   = '0;
    bus.issue_Vk   = '0;
    bus.issue_dest = '0;
    for (int i = 0; i < num_entries; i++) begin
      if (sel[i]) begin
        bus.issue_op   = bus.issue_op   | op_reg[i];
        bus.issue_Vj   = bus.issue_Vj   | vj_reg[i];
        bus.issue_Vk   = bus.issue_Vk   | vk_reg[i];
        bus.issue_dest = bus.issue_dest | dest_reg[i];
      end
    end
  end

  assign bus.issue_valid = |sel;
  assign bus.full        = full;
  assign bus.count       = count_comb;

  always_ff @(posedge clk) begin
    if (flush) begin
      busy_reg     <= '0;
      vj_valid_reg <= '0;
      vk_valid_reg <= '0;
      for (int i = 0; i < num_entries; i++) begin
        op_reg[i]    <= '0;
        vj_reg[i]    <= '0;
        vk_reg[i]    <= '0;
        qj_reg[i]    <= '0;
        qk_reg[i]    <= '0;
        dest_reg[i]  <= '0;
        older_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < num_entries; i++) begin
        if (issue_fire && sel[i]) begin
          busy_reg[i] <= 1'b0;
        end else if (disp_accept && alloc_oh[i]) begin
          busy_reg[i]     <= 1'b1;
          op_reg[i]       <= bus.disp_op;
          vj_reg[i]       <= new_vj;
          vk_reg[i]       <= new_vk;
          qj_reg[i]       <= bus.disp_Qj;
          qk_reg[i]       <= bus.disp_Qk;
          vj_valid_reg[i] <= bus.disp_Vj_valid || bypass_j;
          vk_valid_reg[i] <= bus.disp_Vk_valid || bypass_k;
          dest_reg[i]     <= bus.disp_dest;
        end else if (busy_reg[i]) begin
          if (bus.cdb_valid && !vj_valid_reg[i] && (qj_reg[i] == bus.cdb_tag)) begin
            vj_reg[i]       <= bus.cdb_data;
            vj_valid_reg[i] <= 1'b1;
          end
          if (bus.cdb_valid && !vk_valid_reg[i] && (qk_reg[i] == bus.cdb_tag)) begin
            vk_reg[i]       <= bus.cdb_data;
            vk_valid_reg[i] <= 1'b1;
          end
        end
        // New entry is younger than everything; stale bits of free entries are rewritten on reuse.
        if (disp_accept) begin
          if (alloc_oh[i]) begin
            older_reg[i] <= '0;
          end else begin
            older_reg[i] <= older_reg[i] | alloc_oh;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_res_station_bank.sv
// Directed, table-driven bench for res_station_bank; outputs are checked once per
// cycle after inputs are driven, since they depend only on registered state.
module tb_res_station_bank;
  logic clk;
  logic flush;
  int   checks;
  int   errors;

  res_station_bank_if #(.data_width(16), .tag_width(3), .num_entries(4), .op_width(4)) bus ();

  res_station_bank #(.data_width(16), .tag_width(3), .num_entries(4), .op_width(4)) dut (
    .clk   (clk),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          flush;
    bit          dv;
    logic [3:0]  op;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  qj;
    logic [2:0]  qk;
    bit          vjv;
    bit          vkv;
    logic [2:0]  dest;
    bit          cv;
    logic [2:0]  ctag;
    logic [15:0] cdata;
    bit          ir;
  } in_t;

  typedef struct {
    bit          full;
    logic [2:0]  count;
    bit          iv;
    logic [3:0]  op;
    logic [15:0] vj;
    logic [15:0] vk;
    logic [2:0]  dest;
  } exp_t;

  typedef struct {
    bit   chk;
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vecs[$];

  function automatic in_t idle(bit ir);
    in_t r;
    r = '{default: 0};
    r.ir = ir;
    return r;
  endfunction

  function automatic in_t disp(logic [3:0] op, logic [15:0] vj, logic [15:0] vk,
                               logic [2:0] qj, logic [2:0] qk, bit vjv, bit vkv,
                               logic [2:0] dest, bit ir);
    in_t r;
    r = idle(ir);
    r.dv = 1'b1; r.op = op; r.vj = vj; r.vk = vk; r.qj = qj; r.qk = qk;
    r.vjv = vjv; r.vkv = vkv; r.dest = dest;
    return r;
  endfunction

  function automatic in_t cdb(in_t b, logic [2:0] tag, logic [15:0] data);
    b.cv = 1'b1; b.ctag = tag; b.cdata = data;
    return b;
  endfunction

  function automatic in_t with_flush(in_t b);
    b.flush = 1'b1;
    return b;
  endfunction

  function automatic exp_t none(logic [2:0] cnt, bit full);
    exp_t e;
    e = '{default: 0};
    e.count = cnt; e.full = full;
    return e;
  endfunction

  function automatic exp_t iss(logic [2:0] cnt, bit full, logic [3:0] op,
                               logic [15:0] vj, logic [15:0] vk, logic [2:0] dest);
    exp_t e;
    e.full = full; e.count = cnt; e.iv = 1'b1;
    e.op = op; e.vj = vj; e.vk = vk; e.dest = dest;
    return e;
  endfunction

  task automatic add(bit chk, in_t i, exp_t e);
    vec_t v;
    v.chk = chk; v.i = i; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic set_in(in_t i);
    flush             = i.flush;
    bus.disp_valid    = i.dv;
    bus.disp_op       = i.op;
    bus.disp_Vj       = i.vj;
    bus.disp_Vk       = i.vk;
    bus.disp_Qj       = i.qj;
    bus.disp_Qk       = i.qk;
    bus.disp_Vj_valid = i.vjv;
    bus.disp_Vk_valid = i.vkv;
    bus.disp_dest     = i.dest;
    bus.cdb_valid     = i.cv;
    bus.cdb_tag       = i.ctag;
    bus.cdb_data      = i.cdata;
    bus.issue_ready   = i.ir;
  endtask

  task automatic cmp(string name, string field, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h, required %h", name, field, act, req);
    end
  endtask

  task automatic check_out(string name, exp_t e);
    cmp(name, "full",        32'(bus.full),        32'(e.full));
    cmp(name, "count",       32'(bus.count),       32'(e.count));
    cmp(name, "issue_valid", 32'(bus.issue_valid), 32'(e.iv));
    cmp(name, "issue_op",    32'(bus.issue_op),    32'(e.op));
    cmp(name, "issue_Vj",    32'(bus.issue_Vj),    32'(e.vj));
    cmp(name, "issue_Vk",    32'(bus.issue_Vk),    32'(e.vk));
    cmp(name, "issue_dest",  32'(bus.issue_dest),  32'(e.dest));
  endtask

  // One cycle: drive inputs after the falling edge, then sample before the rising edge.
  task automatic step(bit chk, string name, in_t i, exp_t e);
    @(negedge clk);
    set_in(i);
    #1;
    $display("%-12s flush=%0d dv=%0d cdb=%0d/%0d ir=%0d | full=%0d count=%0d iv=%0d op=%h Vj=%h Vk=%h dest=%0d",
             name, i.flush, i.dv, i.cv, i.ctag, i.ir, bus.full, bus.count, bus.issue_valid,
             bus.issue_op, bus.issue_Vj, bus.issue_Vk, bus.issue_dest);
    if (chk) check_out(name, e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    set_in(with_flush(idle(0)));

    // Flush, single ready dispatch and issue
    add(0, with_flush(idle(0)), none(0, 0));
    add(1, idle(0), none(0, 0));
    add(1, disp(4'h1, 16'h0005, 16'h0003, 0, 0, 1, 1, 3'd2, 1), none(0, 0));
    add(1, idle(1), iss(1, 0, 4'h1, 16'h0005, 16'h0003, 3'd2));
    add(1, idle(0), none(0, 0));
    // Wakeup on Vj after an unrelated broadcast
    add(1, disp(4'h2, 16'h0000, 16'h0007, 3'd4, 0, 0, 1, 3'd3, 0), none(0, 0));
    add(1, cdb(idle(0), 3'd5, 16'h1111), none(1, 0));
    add(1, cdb(idle(0), 3'd4, 16'hBEEF), none(1, 0));
    add(1, idle(0), iss(1, 0, 4'h2, 16'hBEEF, 16'h0007, 3'd3));
    add(1, idle(1), iss(1, 0, 4'h2, 16'hBEEF, 16'h0007, 3'd3));
    // Dispatch bypass from the CDB on Vk
    add(1, cdb(disp(4'h3, 16'h000A, 16'h0000, 0, 3'd1, 1, 0, 3'd5, 0), 3'd1, 16'h1234), none(0, 0));
    add(1, idle(1), iss(1, 0, 4'h3, 16'h000A, 16'h1234, 3'd5));
    // Fill all four entries, drop a fifth, wake out of order
    add(1, disp(4'h8, 16'h0000, 16'h0000, 3'd1, 0, 0, 1, 3'd4, 0), none(0, 0));
    add(1, disp(4'h9, 16'h0000, 16'h0001, 3'd2, 0, 0, 1, 3'd5, 0), none(1, 0));
    add(1, disp(4'hA, 16'h0000, 16'h0002, 3'd3, 0, 0, 1, 3'd6, 0), none(2, 0));
    add(1, disp(4'hB, 16'h0000, 16'h0003, 3'd4, 0, 0, 1, 3'd7, 0), none(3, 0));
    add(1, disp(4'hC, 16'h0C0C, 16'h0C0C, 0, 0, 1, 1, 3'd0, 0), none(4, 1));
    add(1, cdb(idle(0), 3'd3, 16'h0333), none(4, 1));
    add(1, cdb(idle(0), 3'd1, 16'h0111), iss(4, 1, 4'hA, 16'h0333, 16'h0002, 3'd6));
    add(1, idle(1), iss(4, 1, 4'h8, 16'h0111, 16'h0000, 3'd4));
    add(1, idle(1), iss(3, 0, 4'hA, 16'h0333, 16'h0002, 3'd6));
    // Reused low entry is younger than the surviving ones
    add(1, cdb(disp(4'hD, 16'h00F0, 16'h00F1, 0, 0, 1, 1, 3'd1, 0), 3'd4, 16'h0444), none(2, 0));
    add(1, idle(0), iss(3, 0, 4'hB, 16'h0444, 16'h0003, 3'd7));
    add(1, idle(1), iss(3, 0, 4'hB, 16'h0444, 16'h0003, 3'd7));
    add(1, idle(1), iss(2, 0, 4'hD, 16'h00F0, 16'h00F1, 3'd1));
    add(1, cdb(idle(0), 3'd2, 16'h0222), none(1, 0));
    add(1, idle(1), iss(1, 0, 4'h9, 16'h0222, 16'h0001, 3'd5));
    // Dispatch and issue in the same cycle
    add(1, disp(4'h1, 16'h0011, 16'h0022, 0, 0, 1, 1, 3'd2, 0), none(0, 0));
    add(1, disp(4'h2, 16'h0033, 16'h0044, 0, 0, 1, 1, 3'd3, 1), iss(1, 0, 4'h1, 16'h0011, 16'h0022, 3'd2));
    add(1, idle(0), iss(1, 0, 4'h2, 16'h0033, 16'h0044, 3'd3));
    add(1, idle(1), iss(1, 0, 4'h2, 16'h0033, 16'h0044, 3'd3));
    add(1, idle(0), none(0, 0));

    foreach (vecs[k]) begin
      step(vecs[k].chk, $sformatf("vec%0d", k), vecs[k].i, vecs[k].e);
    end

    // Back-pressure: oldest held stable, then both drain in order
    step(1, "hold_p", disp(4'h5, 16'hAAAA, 16'h5555, 0, 0, 1, 1, 3'd6, 0), none(0, 0));
    step(1, "hold_q", disp(4'h6, 16'h1234, 16'h4321, 0, 0, 1, 1, 3'd7, 0),
         iss(1, 0, 4'h5, 16'hAAAA, 16'h5555, 3'd6));
    for (int k = 0; k < 3; k++) begin
      step(1, $sformatf("hold_wait%0d", k), idle(0), iss(2, 0, 4'h5, 16'hAAAA, 16'h5555, 3'd6));
    end
    step(1, "hold_go_p", idle(1), iss(2, 0, 4'h5, 16'hAAAA, 16'h5555, 3'd6));
    step(1, "hold_go_q", idle(1), iss(1, 0, 4'h6, 16'h1234, 16'h4321, 3'd7));
    step(1, "hold_empty", idle(0), none(0, 0));

    // An older entry waking up takes over from a younger held one
    step(1, "pre_r", disp(4'h7, 16'h0000, 16'h0007, 3'd2, 0, 0, 1, 3'd4, 0), none(0, 0));
    step(1, "pre_s", disp(4'h4, 16'h0404, 16'h0505, 0, 0, 1, 1, 3'd5, 0), none(1, 0));
    step(1, "pre_wake", cdb(idle(0), 3'd2, 16'h0202), iss(2, 0, 4'h4, 16'h0404, 16'h0505, 3'd5));
    step(1, "pre_older", idle(0), iss(2, 0, 4'h7, 16'h0202, 16'h0007, 3'd4));
    step(1, "pre_go_r", idle(1), iss(2, 0, 4'h7, 16'h0202, 16'h0007, 3'd4));
    step(1, "pre_go_s", idle(1), iss(1, 0, 4'h4, 16'h0404, 16'h0505, 3'd5));
    step(1, "pre_empty", idle(0), none(0, 0));

    // Flush with busy entries and concurrent dispatch/CDB/issue
    step(1, "fl_d0", disp(4'h1, 16'h0000, 16'h0001, 3'd6, 0, 0, 1, 3'd1, 0), none(0, 0));
    step(1, "fl_d1", disp(4'h2, 16'h0000, 16'h0002, 3'd6, 0, 0, 1, 3'd2, 0), none(1, 0));
    step(1, "fl_d2", disp(4'h3, 16'h0000, 16'h0003, 3'd6, 0, 0, 1, 3'd3, 0), none(2, 0));
    step(1, "fl_flush",
         with_flush(cdb(disp(4'hF, 16'hFFFF, 16'hFFFF, 0, 0, 1, 1, 3'd7, 1), 3'd6, 16'h6666)),
         none(3, 0));
    step(1, "fl_after", cdb(idle(1), 3'd6, 16'h6666), none(0, 0));
    step(1, "fl_quiet", idle(1), none(0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/res_station_bank.md
Name: res_station_bank

Overview:
- Parametrised N-entry reservation station bank: generalises the single-entry station into a pool with allocation, CDB snooping (operand wakeup) and oldest-first issue to one functional unit.
- Sits between the dispatch stage (fed from the register file/ROB) and one execution unit.
- Listens to the common data bus and frees an entry when its instruction issues.

Parameters:
- data_width, 16, operand value width.
- tag_width, 3, ROB tag width for Qj/Qk/dest.
- num_entries, 4, number of station entries (>=2).
- op_width, 4, opcode width (lc3b_opcode).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- flush  in  1  synchronous active-high reset/clear; clears the whole bank.
- disp_valid  in  1  dispatch request this cycle.
- disp_op  in  op_width  opcode.
- disp_Vj, disp_Vk  in  data_width  operand values.
- disp_Qj, disp_Qk  in  tag_width  producer tags.
- disp_Vj_valid, disp_Vk_valid  in  1  operand value already present.
- disp_dest  in  tag_width  destination ROB tag.
- full  out  1  all entries busy; dispatch not accepted.
- count  out  $clog2(num_entries+1)  number of busy entries.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  tag_width  broadcast tag.
- cdb_data  in  data_width  broadcast value.
- issue_ready  in  1  functional unit accepts.
- issue_valid  out  1  a ready entry is presented.
- issue_op  out  op_width.
- issue_Vj, issue_Vk  out  data_width.
- issue_dest  out  tag_width.

Behaviour:
- Per-entry state: busy, op, Vj, Vk, Qj, Qk, Vj_valid, Vk_valid, dest, plus age ordering (age matrix or equivalent).
- Reset/flush: on flush high, at the edge all busy and valid bits clear and all stored fields zero; dispatch, CDB and issue that cycle are ignored.
  - After flush: full=0, count=0, issue_valid=0, issue_* = 0.
- Allocation:
  - Dispatch accepted iff disp_valid && !full.
  - Writes the lowest-index non-busy entry, using start-of-cycle state.
  - An entry freed by issue in the same cycle is not reused until the next cycle.
  - full and count are derived from registered state only.
  - A dispatch while full is dropped silently; upstream must stall on full.
- Dispatch bypass: if cdb_valid, the operand is not valid and disp_Qx==cdb_tag, store cdb_data with valid=1 instead of the tag.
- Wakeup: every busy entry with Vx_valid=0 and Qx==cdb_tag while cdb_valid loads Vx=cdb_data and sets Vx_valid=1 at the edge. Both operands may wake in the same cycle.
- Ready entry: busy && Vj_valid && Vk_valid, evaluated on registered state. A CDB wakeup makes an entry eligible one cycle later. An entry dispatched with both operands valid is eligible the cycle after dispatch.
- Issue selection: oldest ready entry by dispatch order.
  - issue_* outputs are combinational from registered state.
  - issue_valid=0 forces issue_* to 0.
- Issue handshake:
  - On issue_valid && issue_ready, the selected entry clears busy at the edge.
  - With issue_ready low, the same entry stays presented and its outputs stay stable, unless an older entry becomes ready, which takes priority next cycle.
- count updates each edge: +1 on accepted dispatch, -1 on issue, unchanged when both occur.
- Age order: a new entry is younger than all busy entries; order is unaffected by frees.
- Width rules: no arithmetic on data; tags are compared for full-width equality only.

Test Plan:
- Flush then idle -> full=0, count=0, issue_valid=0; dispatch op=ADD, Vj=0x0005, Vk=0x0003, both valid, dest=2 -> next cycle issue_valid=1, issue_Vj=0x0005, issue_Vk=0x0003, issue_dest=2; with issue_ready=1, count returns to 0.
- Dispatch with Qj=4 and Vj_valid=0 -> no issue. Two cycles later CDB tag=4, data=0xBEEF -> issue_valid=1 the following cycle with issue_Vj=0xBEEF. CDB tag=5 has no effect.
- Dispatch Qk=1 with Vk_valid=0 in the same cycle as CDB tag=1, data=0x1234 -> entry stores Vk=0x1234 and issues the next cycle.
- Fill 4 entries whose operands wait on tags 1..4 -> full=1, count=4. A 5th dispatch is dropped. CDB broadcasts tags 3 then 1 -> issue order follows dispatch age: entry with tag 1 first, then the entry with tag 3.
- Two ready entries, issue_ready=0 for 3 cycles -> the oldest is held with stable outputs. Raising issue_ready issues the oldest, then the younger one next cycle.
- Flush asserted with 3 busy entries and cdb_valid=1 -> next cycle count=0 and issue_valid=0; a later CDB broadcast causes no issue.
